// File: rtl/unified_mem_arbiter_if.sv
// Pipeline-side and memory-side signals of the unified memory arbiter.
// The slave modport is the arbiter; the master modport is the pipeline plus memory.
interface unified_mem_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ready;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        mport_en;
  logic        mport_we;
  logic [31:0] mport_addr;
  logic [31:0] mport_wdata;
  logic [31:0] mport_rdata;

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mport_rdata,
    input  if_rdata, if_ready, mem_rdata, mem_ready,
           mport_en, mport_we, mport_addr, mport_wdata
  );

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, mport_rdata,
    output if_rdata, if_ready, mem_rdata, mem_ready,
           mport_en, mport_we, mport_addr, mport_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Shares one fixed-latency single-ported memory between the IF and MEM stages,
// stalls the pipeline until every pending access is serviced, counts stall cycles.
module unified_mem_arbiter #(
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 32
) (
  input  logic                 clock,
  input  logic                 reset,
  unified_mem_arbiter_if.slave bus,
  output logic                 align_err,
  output logic                 stall,
  output logic [CNT_W-1:0]     stall_cycles
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t      state;
  logic        owner_mem;
  logic        owner_we;
  logic        bad_acc;
  logic        if_done;
  logic        mem_done;
  logic [3:0]  lat_cnt;
  logic [31:0] if_rdata_q;
  logic [31:0] mem_rdata_q;
  logic        pend_if;
  logic        pend_mem;
  logic [31:0] win_addr;

  // MEM wins over IF: its instruction is older.
  always_comb begin
    pend_if  = bus.if_req & ~if_done;
    pend_mem = bus.mem_req & ~mem_done;
    stall    = pend_if | pend_mem;
    win_addr = pend_mem ? bus.mem_addr : bus.if_addr;
  end

  assign bus.if_ready  = if_done;
  assign bus.mem_ready = mem_done;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.mem_rdata = mem_rdata_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state           <= IDLE;
      owner_mem       <= 1'b0;
      owner_we        <= 1'b0;
      bad_acc         <= 1'b0;
      if_done         <= 1'b0;
      mem_done        <= 1'b0;
      lat_cnt         <= '0;
      if_rdata_q      <= '0;
      mem_rdata_q     <= '0;
      align_err       <= 1'b0;
      stall_cycles    <= '0;
      bus.mport_en    <= 1'b0;
      bus.mport_we    <= 1'b0;
      bus.mport_addr  <= '0;
      bus.mport_wdata <= '0;
    end else begin
      if (stall) begin
        stall_cycles <= stall_cycles + CNT_W'(1);
      end else begin
        if_done  <= 1'b0;
        mem_done <= 1'b0;
      end

      // Done flags are set below the clear so a completion landing on an
      // unstalled edge (requester dropped req mid-access) still sticks.
      case (state)
        IDLE: begin
          if (stall) begin
            owner_mem <= pend_mem;
            owner_we  <= pend_mem & bus.mem_we;
            if (win_addr[1:0] != 2'b00) begin
              bad_acc   <= 1'b1;
              align_err <= 1'b1;
              if (pend_mem) mem_rdata_q <= '0;
              else          if_rdata_q  <= '0;
              state <= RESP;
            end else begin
              bad_acc         <= 1'b0;
              bus.mport_en    <= 1'b1;
              bus.mport_we    <= pend_mem & bus.mem_we;
              bus.mport_addr  <= win_addr;
              bus.mport_wdata <= pend_mem ? bus.mem_wdata : '0;
              state           <= ISSUE;
            end
          end
        end
        ISSUE: begin
          bus.mport_en <= 1'b0;
          bus.mport_we <= 1'b0;
          lat_cnt      <= 4'(MEM_LAT);
          state        <= WAIT;
        end
        WAIT: begin
          lat_cnt <= lat_cnt - 4'd1;
          if (lat_cnt == 4'd1) begin
            if (!owner_we) begin
              if (owner_mem) mem_rdata_q <= bus.mport_rdata;
              else           if_rdata_q  <= bus.mport_rdata;
            end
            if (owner_mem) mem_done <= 1'b1;
            else           if_done  <= 1'b1;
            state <= RESP;
          end
        end
        RESP: begin
          if (bad_acc) begin
            if (owner_mem) mem_done <= 1'b1;
            else           if_done  <= 1'b1;
          end
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: per-cycle vector table on a MEM_LAT=2
// instance, plus hand-written reset-mid-access and MEM_LAT=1 sequences.
module tb_unified_mem_arbiter;

  localparam logic H = 1'b1;
  localparam logic L = 1'b0;
  localparam logic [31:0] Z   = 32'h0;
  localparam logic [31:0] A4  = 32'h4;
  localparam logic [31:0] A8  = 32'h8;
  localparam logic [31:0] A10 = 32'h10;
  localparam logic [31:0] A13 = 32'h13;
  localparam logic [31:0] A40 = 32'h40;
  localparam logic [31:0] I0  = 32'h2001000A;
  localparam logic [31:0] I8  = 32'h00221820;
  localparam logic [31:0] D40 = 32'hDEADBEEF;
  localparam logic [31:0] I4  = 32'hA5A5A5A1;
  localparam logic [31:0] SW  = 32'h12345678;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  unified_mem_arbiter_if b0 ();
  unified_mem_arbiter_if b1 ();
  logic        err0, stall0, err1, stall1;
  logic [31:0] cnt0, cnt1;

  unified_mem_arbiter #(.MEM_LAT(2), .CNT_W(32)) u0 (
    .clock(clock), .reset(reset), .bus(b0.slave),
    .align_err(err0), .stall(stall0), .stall_cycles(cnt0)
  );
  unified_mem_arbiter #(.MEM_LAT(1), .CNT_W(32)) u1 (
    .clock(clock), .reset(reset), .bus(b1.slave),
    .align_err(err1), .stall(stall1), .stall_cycles(cnt1)
  );

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0:   return I0;
      32'h8:   return I8;
      32'h40:  return D40;
      default: return a ^ 32'hA5A5A5A5;
    endcase
  endfunction

  // Memory models: data valid exactly MEM_LAT cycles after the strobe cycle, poison otherwise.
  logic [1:0]  pv0 = '0;
  logic [31:0] pa0_0 = '0, pa0_1 = '0;
  logic        pv1 = 1'b0;
  logic [31:0] pa1 = '0;
  always @(posedge clock) begin
    pv0   <= {pv0[0], b0.mport_en};
    pa0_0 <= b0.mport_addr;
    pa0_1 <= pa0_0;
    pv1   <= b1.mport_en;
    pa1   <= b1.mport_addr;
  end
  assign b0.mport_rdata = pv0[1] ? mem_rd(pa0_1) : 32'hBAD0BAD0;
  assign b1.mport_rdata = pv1    ? mem_rd(pa1)   : 32'hBAD0BAD0;

  typedef struct {
    logic rst; logic ir; logic [31:0] ia; logic mr; logic mw; logic [31:0] ma; logic [31:0] md;
    logic chk;
    logic st; logic en; logic we; logic [31:0] pa; logic [31:0] pd;
    logic iy; logic [31:0] ird; logic my; logic [31:0] mrd; logic er; logic [31:0] cn;
  } vec_t;

  int n_vec = 0;
  int n_bad = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic drv0(input logic r, input logic ir, input logic [31:0] ia,
                      input logic mr, input logic mw, input logic [31:0] ma, input logic [31:0] md);
    reset        = r;
    b0.if_req    = ir;
    b0.if_addr   = ia;
    b0.mem_req   = mr;
    b0.mem_we    = mw;
    b0.mem_addr  = ma;
    b0.mem_wdata = md;
  endtask

  vec_t vt[$];

  initial begin
    int rdy_k, en_at, en_n, rdy_at;
    logic [31:0] got;

    b1.if_req = 1'b0; b1.if_addr = '0; b1.mem_req = 1'b0;
    b1.mem_we = 1'b0; b1.mem_addr = '0; b1.mem_wdata = '0;
    drv0(H, L, Z, L, L, Z, Z);

    // single fetch
    vt.push_back('{H,L,Z,L,L,Z,Z, L, L,L,L,Z,Z, L,Z,L,Z,L,32'd0});
    vt.push_back('{L,L,Z,L,L,Z,Z, H, L,L,L,Z,Z, L,Z,L,Z,L,32'd0});
    vt.push_back('{L,H,Z,L,L,Z,Z, H, H,L,L,Z,Z, L,Z,L,Z,L,32'd0});
    vt.push_back('{L,H,Z,L,L,Z,Z, H, H,H,L,Z,Z, L,Z,L,Z,L,32'd1});
    vt.push_back('{L,H,Z,L,L,Z,Z, H, H,L,L,Z,Z, L,Z,L,Z,L,32'd2});
    vt.push_back('{L,H,Z,L,L,Z,Z, H, H,L,L,Z,Z, L,Z,L,Z,L,32'd3});
    vt.push_back('{L,H,Z,L,L,Z,Z, H, L,L,L,Z,Z, H,I0,L,Z,L,32'd4});
    vt.push_back('{L,L,Z,L,L,Z,Z, H, L,L,L,Z,Z, L,I0,L,Z,L,32'd4});
    // simultaneous load + fetch: MEM first
    vt.push_back('{H,L,Z,L,L,Z,Z, L, L,L,L,Z,Z, L,Z,L,Z,L,32'd0});
    vt.push_back('{L,H,A8,H,L,A40,Z, H, H,L,L,Z,Z,   L,Z,L,Z,L,32'd0});
    vt.push_back('{L,H,A8,H,L,A40,Z, H, H,H,L,A40,Z, L,Z,L,Z,L,32'd1});
    vt.push_back('{L,H,A8,H,L,A40,Z, H, H,L,L,Z,Z,   L,Z,L,Z,L,32'd2});
    vt.push_back('{L,H,A8,H,L,A40,Z, H, H,L,L,Z,Z,   L,Z,L,Z,L,32'd3});
    vt.push_back('{L,H,A8,H,L,A40,Z, H, H,L,L,Z,Z,   L,Z,H,D40,L,32'd4});
    vt.push_back('{L,H,A8,H,L,A40,Z, H, H,L,L,Z,Z,   L,Z,H,D40,L,32'd5});
    vt.push_back('{L,H,A8,H,L,A40,Z, H, H,H,L,A8,Z,  L,Z,H,D40,L,32'd6});
    vt.push_back('{L,H,A8,H,L,A40,Z, H, H,L,L,Z,Z,   L,Z,H,D40,L,32'd7});
    vt.push_back('{L,H,A8,H,L,A40,Z, H, H,L,L,Z,Z,   L,Z,H,D40,L,32'd8});
    vt.push_back('{L,H,A8,H,L,A40,Z, H, L,L,L,Z,Z,   H,I8,H,D40,L,32'd9});
    vt.push_back('{L,L,Z,L,L,Z,Z,    H, L,L,L,Z,Z,   L,I8,L,D40,L,32'd9});
    // store: load data register untouched
    vt.push_back('{L,L,Z,H,H,A10,SW, H, H,L,L,Z,Z,    L,I8,L,D40,L,32'd9});
    vt.push_back('{L,L,Z,H,H,A10,SW, H, H,H,H,A10,SW, L,I8,L,D40,L,32'd10});
    vt.push_back('{L,L,Z,H,H,A10,SW, H, H,L,L,Z,Z,    L,I8,L,D40,L,32'd11});
    vt.push_back('{L,L,Z,H,H,A10,SW, H, H,L,L,Z,Z,    L,I8,L,D40,L,32'd12});
    vt.push_back('{L,L,Z,H,H,A10,SW, H, L,L,L,Z,Z,    L,I8,H,D40,L,32'd13});
    vt.push_back('{L,L,Z,L,L,Z,Z,    H, L,L,L,Z,Z,    L,I8,L,D40,L,32'd13});
    // misaligned load
    vt.push_back('{L,L,Z,H,L,A13,Z, H, H,L,L,Z,Z, L,I8,L,D40,L,32'd13});
    vt.push_back('{L,L,Z,H,L,A13,Z, H, H,L,L,Z,Z, L,I8,L,Z,H,32'd14});
    vt.push_back('{L,L,Z,H,L,A13,Z, H, L,L,L,Z,Z, L,I8,H,Z,H,32'd15});
    vt.push_back('{L,L,Z,L,L,Z,Z,   H, L,L,L,Z,Z, L,I8,L,Z,H,32'd15});
    // fetch whose req drops while in flight
    vt.push_back('{H,L,Z,L,L,Z,Z,  L, L,L,L,Z,Z,  L,Z,L,Z,L,32'd0});
    vt.push_back('{L,H,A4,L,L,Z,Z, H, H,L,L,Z,Z,  L,Z,L,Z,L,32'd0});
    vt.push_back('{L,L,A4,L,L,Z,Z, H, L,H,L,A4,Z, L,Z,L,Z,L,32'd1});
    vt.push_back('{L,L,A4,L,L,Z,Z, H, L,L,L,Z,Z,  L,Z,L,Z,L,32'd1});
    vt.push_back('{L,L,A4,L,L,Z,Z, H, L,L,L,Z,Z,  L,Z,L,Z,L,32'd1});
    vt.push_back('{L,L,A4,L,L,Z,Z, H, L,L,L,Z,Z,  H,I4,L,Z,L,32'd1});
    vt.push_back('{L,L,A4,L,L,Z,Z, H, L,L,L,Z,Z,  L,I4,L,Z,L,32'd1});

    foreach (vt[i]) begin
      @(negedge clock);
      drv0(vt[i].rst, vt[i].ir, vt[i].ia, vt[i].mr, vt[i].mw, vt[i].ma, vt[i].md);
      #2;
      if (vt[i].chk) begin
        cmp($sformatf("v%0d.stall", i), 32'(stall0), 32'(vt[i].st));
        cmp($sformatf("v%0d.mport_en", i), 32'(b0.mport_en), 32'(vt[i].en));
        cmp($sformatf("v%0d.mport_we", i), 32'(b0.mport_we), 32'(vt[i].we));
        if (vt[i].en) cmp($sformatf("v%0d.mport_addr", i), b0.mport_addr, vt[i].pa);
        if (vt[i].we) cmp($sformatf("v%0d.mport_wdata", i), b0.mport_wdata, vt[i].pd);
        cmp($sformatf("v%0d.if_ready", i), 32'(b0.if_ready), 32'(vt[i].iy));
        cmp($sformatf("v%0d.if_rdata", i), b0.if_rdata, vt[i].ird);
        cmp($sformatf("v%0d.mem_ready", i), 32'(b0.mem_ready), 32'(vt[i].my));
        cmp($sformatf("v%0d.mem_rdata", i), b0.mem_rdata, vt[i].mrd);
        cmp($sformatf("v%0d.align_err", i), 32'(err0), 32'(vt[i].er));
        cmp($sformatf("v%0d.stall_cycles", i), cnt0, vt[i].cn);
      end
    end

    // reset in cycle 3 of a fetch, then a fresh fetch
    @(negedge clock); drv0(H, L, Z, L, L, Z, Z);
    @(negedge clock); drv0(L, H, Z, L, L, Z, Z);
    @(negedge clock);
    @(negedge clock);
    @(negedge clock); drv0(H, L, Z, L, L, Z, Z);
    @(negedge clock); drv0(L, L, Z, L, L, Z, Z);
    #2;
    cmp("rst.stall", 32'(stall0), 32'd0);
    cmp("rst.mport_en", 32'(b0.mport_en), 32'd0);
    cmp("rst.mport_addr", b0.mport_addr, 32'd0);
    cmp("rst.if_ready", 32'(b0.if_ready), 32'd0);
    cmp("rst.if_rdata", b0.if_rdata, 32'd0);
    cmp("rst.stall_cycles", cnt0, 32'd0);
    @(negedge clock); drv0(L, H, Z, L, L, Z, Z);
    #2;
    cmp("rst.late_rdata", b0.if_rdata, 32'd0);
    cmp("rst.fsm_idle_restart", 32'(stall0), 32'd1);
    rdy_k = 0;
    got = '0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock); #2;
      if (b0.if_ready && rdy_k == 0) begin
        rdy_k = k;
        got = b0.if_rdata;
        b0.if_req = 1'b0;
      end
    end
    cmp("rst.relaunch_latency", rdy_k, 32'd4);
    cmp("rst.relaunch_rdata", got, I0);

    // MEM_LAT=1 instance
    @(negedge clock);
    b1.if_req  = 1'b1;
    b1.if_addr = A8;
    en_at = 0; en_n = 0; rdy_at = 0; got = '0;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clock); #2;
      if (b1.mport_en) begin
        en_n++;
        if (en_at == 0) en_at = c;
      end
      if (b1.if_ready && rdy_at == 0) begin
        rdy_at = c;
        got = b1.if_rdata;
        b1.if_req = 1'b0;
      end
    end
    cmp("lat1.en_cycle", en_at, 32'd1);
    cmp("lat1.en_count", en_n, 32'd1);
    cmp("lat1.ready_cycle", rdy_at, 32'd3);
    cmp("lat1.if_rdata", got, I8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
